// File: rtl/debounce_pkg.sv
// debounce_pkg: shared FSM encodings and timing defaults for the key debouncer
package debounce_pkg;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_TIMING = 2'd1;
  localparam logic [1:0] S_COMMIT = 2'd2;
  localparam int DEF_TICK_DIV = 5;
  localparam int DEF_HOLD_MS = 10;
endpackage

// File: rtl/debounce_timebase.sv
// debounce_timebase: shared ms prescaler and hold counter, done after HOLD_MS ticks
import debounce_pkg::*;
module debounce_timebase #(
  parameter int TICK_DIV = DEF_TICK_DIV,
  parameter int HOLD_MS = DEF_HOLD_MS
)(
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic done
);
  localparam int PW = (TICK_DIV > 0) ? $clog2(TICK_DIV + 1) : 1;
  logic [PW-1:0] presc;
  logic [3:0] ms;
  logic tick;
  assign tick = presc == PW'(TICK_DIV);
  assign done = tick && ms == 4'(HOLD_MS - 1);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      presc <= '0;
      ms <= '0;
    end else if (clr) begin
      presc <= '0;
      ms <= '0;
    end else begin
      presc <= tick ? '0 : presc + 1'b1;
      ms <= tick ? ms + 1'b1 : ms;
    end
endmodule

// File: rtl/key_debounce_arbiter.sv
// key_debounce_arbiter: debounces N active-low keys through one round-robin shared hold timer
import debounce_pkg::*;
module key_debounce_arbiter #(
  parameter int N_KEYS = 4,
  parameter int TICK_DIV = DEF_TICK_DIV,
  parameter int HOLD_MS = DEF_HOLD_MS,
  parameter int IDX_W = (N_KEYS > 2) ? $clog2(N_KEYS) : 1
)(
  input  logic              CLK,
  input  logic              RST,
  input  logic [N_KEYS-1:0] Key_In,
  output logic [N_KEYS-1:0] Key_Level,
  output logic [N_KEYS-1:0] Key_Press,
  output logic [N_KEYS-1:0] Key_Release,
  output logic              Busy,
  output logic [IDX_W-1:0]  Grant_Idx
);
  logic [N_KEYS-1:0] sync1, sraw, req;
  logic [1:0] state;
  logic [IDX_W-1:0] rr_ptr, pick, nxt;
  logic target, done;
  // a key requests service while its synced pin still disagrees with the debounced level
  assign req = ~(sraw ^ Key_Level);
  assign Busy = state == S_TIMING || state == S_COMMIT;
  assign nxt = (Grant_Idx == IDX_W'(N_KEYS - 1)) ? '0 : Grant_Idx + 1'b1;
  always_comb begin
    pick = rr_ptr;
    for (int k = N_KEYS - 1; k >= 0; k--)
      if (req[(int'(rr_ptr) + k) % N_KEYS]) pick = IDX_W'((int'(rr_ptr) + k) % N_KEYS);
  end
  debounce_timebase #(.TICK_DIV(TICK_DIV), .HOLD_MS(HOLD_MS)) u_tb (
    .clk(CLK),
    .rst(RST),
    .clr(state != S_TIMING),
    .done(done)
  );
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      sync1 <= '1;
      sraw <= '1;
      state <= S_IDLE;
      rr_ptr <= '0;
      Grant_Idx <= '0;
      target <= 1'b0;
      Key_Level <= '0;
      Key_Press <= '0;
      Key_Release <= '0;
    end else begin
      sync1 <= Key_In;
      sraw <= sync1;
      Key_Press <= '0;
      Key_Release <= '0;
      case (state)
        S_IDLE:
          if (|req) begin
            Grant_Idx <= pick;
            target <= ~sraw[pick];
            state <= S_TIMING;
          end
        S_TIMING:
          if (!req[Grant_Idx]) begin
            rr_ptr <= nxt;
            state <= S_IDLE;
          end else if (done) state <= S_COMMIT;
        S_COMMIT: begin
          Key_Level[Grant_Idx] <= target;
          Key_Press[Grant_Idx] <= target;
          Key_Release[Grant_Idx] <= ~target;
          rr_ptr <= nxt;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
endmodule

// File: tb/tb_key_debounce_arbiter.sv
// tb_key_debounce_arbiter: directed stimulus with a pulse scoreboard checked by a monitor
module tb_key_debounce_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] key_in = 4'b1111;
  logic [3:0] key_level, key_press, key_release;
  logic busy;
  logic [1:0] grant_idx;
  int cyc = 0;
  int passed = 0;
  int total = 0;
  typedef struct {
    int cyc;
    logic [3:0] press;
    logic [3:0] rel;
    logic [3:0] lvl;
  } ev_t;
  ev_t sb[$];

  key_debounce_arbiter dut (
    .CLK(clk),
    .RST(rst),
    .Key_In(key_in),
    .Key_Level(key_level),
    .Key_Press(key_press),
    .Key_Release(key_release),
    .Busy(busy),
    .Grant_Idx(grant_idx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    else passed++;
  endtask

  task automatic push(input int c, input logic [3:0] p, input logic [3:0] r, input logic [3:0] l);
    ev_t e;
    e.cyc = c;
    e.press = p;
    e.rel = r;
    e.lvl = l;
    sb.push_back(e);
  endtask

  task automatic to_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  always @(negedge clk)
    if (|key_press || |key_release) begin
      if (sb.size() == 0) begin
        total++;
        $display("FAIL unexpected_pulse at cycle %0d: press %b release %b, none expected", cyc, key_press, key_release);
      end else begin
        ev_t e;
        e = sb.pop_front();
        check("pulse_cycle", cyc, e.cyc);
        check("press_mask", key_press, e.press);
        check("release_mask", key_release, e.rel);
        check("level_at_pulse", key_level, e.lvl);
      end
    end

  initial begin
    int c;
    repeat (2) @(negedge clk);
    check("rst_level", key_level, 4'b0000);
    check("rst_press", key_press, 4'b0000);
    check("rst_release", key_release, 4'b0000);
    check("rst_busy", busy, 1'b0);
    check("rst_grant", grant_idx, 2'd0);
    rst = 1'b0;
    to_cyc(cyc + 200);
    check("idle_level", key_level, 4'b0000);
    check("idle_busy", busy, 1'b0);

    // clean press and release of key 2
    key_in = 4'b1011;
    c = cyc;
    push(c + 64, 4'b0100, 4'b0000, 4'b0100);
    to_cyc(c + 10);
    check("k2_busy", busy, 1'b1);
    check("k2_grant", grant_idx, 2'd2);
    to_cyc(c + 63);
    check("k2_level_early", key_level, 4'b0000);
    to_cyc(c + 70);
    key_in = 4'b1111;
    c = cyc;
    push(c + 64, 4'b0000, 4'b0100, 4'b0000);
    to_cyc(c + 70);

    // key 1 bounces: 30 low, 5 high, then low for good
    key_in = 4'b1101;
    c = cyc;
    to_cyc(c + 30);
    key_in = 4'b1111;
    to_cyc(c + 35);
    key_in = 4'b1101;
    c = cyc;
    push(c + 64, 4'b0010, 4'b0000, 4'b0010);
    to_cyc(c + 70);
    key_in = 4'b1111;
    c = cyc;
    push(c + 64, 4'b0000, 4'b0010, 4'b0000);
    to_cyc(c + 70);

    // reset in the middle of timing key 2
    key_in = 4'b1011;
    c = cyc;
    to_cyc(c + 29);
    check("mid_busy", busy, 1'b1);
    check("mid_grant", grant_idx, 2'd2);
    to_cyc(c + 30);
    rst = 1'b1;
    #1;
    check("async_rst_busy", busy, 1'b0);
    check("async_rst_grant", grant_idx, 2'd0);
    check("async_rst_level", key_level, 4'b0000);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    c = cyc;
    push(c + 64, 4'b0100, 4'b0000, 4'b0100);
    to_cyc(c + 70);
    key_in = 4'b1111;
    c = cyc;
    push(c + 64, 4'b0000, 4'b0100, 4'b0000);
    to_cyc(c + 70);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;

    // keys 0 and 3 together from rr_ptr 0
    key_in = 4'b0110;
    c = cyc;
    push(c + 64, 4'b0001, 4'b0000, 4'b0001);
    push(c + 126, 4'b1000, 4'b0000, 4'b1001);
    to_cyc(c + 70);
    check("sim_grant", grant_idx, 2'd3);
    check("sim_busy", busy, 1'b1);
    to_cyc(c + 130);
    key_in = 4'b1111;
    c = cyc;
    push(c + 64, 4'b0000, 4'b0001, 4'b1000);
    push(c + 126, 4'b0000, 4'b1000, 4'b0000);
    to_cyc(c + 130);

    // fairness: key 0 re-requests right after its commit, key 1 still wins next
    key_in = 4'b1100;
    c = cyc;
    push(c + 64, 4'b0001, 4'b0000, 4'b0001);
    to_cyc(c + 62);
    key_in = 4'b1101;
    push(c + 126, 4'b0010, 4'b0000, 4'b0011);
    push(c + 188, 4'b0000, 4'b0001, 4'b0010);
    to_cyc(c + 66);
    check("rr_grant", grant_idx, 2'd1);
    check("rr_busy", busy, 1'b1);
    to_cyc(c + 190);
    key_in = 4'b1111;
    c = cyc;
    push(c + 64, 4'b0000, 4'b0010, 4'b0000);
    to_cyc(c + 70);

    check("end_busy", busy, 1'b0);
    check("end_level", key_level, 4'b0000);
    check("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/key_debounce_arbiter.md
Name: key_debounce_arbiter

Overview:
- Debounces N active-low push-buttons for the clock's set/mode keys using one shared millisecond timebase and one hold timer.
- Instead of one delay counter per key, a round-robin arbiter grants the timer to one key at a time.
- Provides a debounced level and single-cycle press/release pulses per key to the time-setting FSM.

Parameters:
- N_KEYS, 4, number of key inputs (2..8).
- TICK_DIV, 5, prescaler terminal count; one ms tick = TICK_DIV+1 CLK cycles.
- HOLD_MS, 10, ms ticks a new raw level must hold before commit (1..15).
- IDX_W, 2, grant index width = max(1, clog2(N_KEYS)).

Ports:
- CLK  input  1  system clock, rising edge.
- RST  input  1  asynchronous active-high reset.
- Key_In  input  N_KEYS  raw key pins, low = pressed, asynchronous to CLK.
- Key_Level  output  N_KEYS  debounced state, 1 = pressed.
- Key_Press  output  N_KEYS  one-cycle pulse when Key_Level[i] rises.
- Key_Release  output  N_KEYS  one-cycle pulse when Key_Level[i] falls.
- Busy  output  1  timer granted (state TIMING or COMMIT).
- Grant_Idx  output  IDX_W  key currently owning the timer; holds last value when idle.

Behaviour:
- Reset values: Key_Level, Key_Press, Key_Release, Busy, Grant_Idx, rr_ptr, prescaler and ms counter = 0. Sync flops = 1, so released keys raise no request. State = IDLE.
- Sync: two-flop synchronizer per key; sraw[i] is the second stage.
- Request: req[i] = (sraw[i] == Key_Level[i]), i.e. synced raw disagrees with the debounced state. Requests are level-based and are never lost while another key is served.
- FSM IDLE:
  - If any req, grant the first set req at index >= rr_ptr, wrapping modulo N_KEYS.
  - Latch Grant_Idx and target = ~sraw[idx]. Clear prescaler and ms counter. Go to TIMING.
  - Otherwise stay in IDLE.
- FSM TIMING:
  - Prescaler counts 0..TICK_DIV and wraps.
  - On prescaler == TICK_DIV, ms counter increments.
  - Bounce: if req[Grant_Idx] drops, abort. Go to IDLE with no output change; rr_ptr = Grant_Idx+1 mod N_KEYS. The key re-requests later and restarts the full hold.
  - Complete: if prescaler == TICK_DIV and ms counter == HOLD_MS-1, go to COMMIT. Bounce takes priority if both occur in the same cycle.
- FSM COMMIT (one cycle):
  - Key_Level[Grant_Idx] <= target.
  - Key_Press[Grant_Idx] <= target; Key_Release[Grant_Idx] <= ~target. Both pulses are registered and high for exactly one cycle.
  - rr_ptr <= Grant_Idx+1 mod N_KEYS. Go to IDLE.
- Latency: a clean change sampled on edge 1 (edge 2 for sync2) updates Key_Level after edge 4 + HOLD_MS*(TICK_DIV+1). With defaults this is edge 64.
- Back-to-back: after COMMIT, a pending request is granted on the IDLE cycle, so there is one idle cycle between grants.
- Simultaneous requests are served in round-robin order from rr_ptr. A waiting key's latency grows by the whole service time of the keys ahead of it.
- Counter widths: prescaler uses clog2(TICK_DIV+1) bits, ms counter 4 bits. Neither can overflow, since both are cleared on grant.
- Reset mid-operation clears everything immediately, with no pulse emitted.
- Pulses on non-granted keys are always 0.

Decomposition:
- Shared package (debounce_pkg):
  - State encodings S_IDLE=2'd0, S_TIMING=2'd1, S_COMMIT=2'd2.
  - Default constants TICK_DIV, HOLD_MS.
- Sub-module debounce_timebase:
  - Holds the prescaler and ms counter, with a clear input and a done output at HOLD_MS.
  - Instantiated once, owned by the arbiter FSM.
- The round-robin pick stays inline as combinational logic.

Test Plan:
- Reset then idle: Key_In=4'b1111 for 200 cycles -> all outputs 0, Busy=0.
- Clean press of key 2: Key_In[2] 1->0 sampled edge 1 -> Key_Level[2]=1 after edge 64, Key_Press[2]=1 for one cycle. Later release -> Key_Release[2] pulse after another 64.
- Bounce: key 1 low 30 cycles, high 5, then low -> Key_Level unchanged until 64 cycles after the final low is sampled; exactly one Key_Press[1].
- Simultaneous: keys 0 and 3 pressed same cycle, rr_ptr=0 -> Key_Press[0] at edge 64. Key_Press[3] at edge 64+62=126 (one idle cycle, then the full hold).
- Round-robin fairness: keys 0,1 held toggling continuously after a commit on key 0 -> next grant goes to key 1 (Grant_Idx=1).
- RST asserted mid-TIMING (edge 30) -> outputs 0 asynchronously, no pulse. After release, the press is re-debounced from scratch: 64 cycles from deassertion.
